// File: rtl/regfile_wb_scheduler.sv
// Round-robin writeback arbiter for a single register-file write port, with a registered
// output stage and a pending-write (busy) scoreboard used by issue logic for RAW stalls.
module regfile_wb_scheduler #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ*5-1:0]    i_req_addr,
  input  logic [NREQ*XLEN-1:0] i_req_data,
  input  logic                 i_issue_valid,
  input  logic [4:0]           i_issue_rd,
  input  logic [4:0]           i_rs1_addr,
  input  logic [4:0]           i_rs2_addr,
  output logic                 o_rs1_busy,
  output logic                 o_rs2_busy,
  output logic [31:0]          o_busy_map,
  output logic                 o_rd_wvalid,
  output logic [4:0]           o_rd_waddr,
  output logic [XLEN-1:0]      o_rd_wdata
);

  localparam int unsigned PtrW = $clog2(NREQ);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW:0]   arb_sum;
  logic [NREQ-1:0] grant;
  logic [PtrW-1:0] grant_idx;
  logic            grant_any;
  logic            transfer;
  logic [4:0]      sel_addr;
  logic [XLEN-1:0] sel_data;
  logic            load_wb;

  logic            wvalid_q;
  logic [4:0]      waddr_q;
  logic [XLEN-1:0] wdata_q;
  logic [31:0]     busy_q, busy_d;

  logic [4:0]      req_addr_a [NREQ];
  logic [XLEN-1:0] req_data_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_addr_a[g] = i_req_addr[5*g +: 5];
    assign req_data_a[g] = i_req_data[XLEN*g +: XLEN];
  end

  // First valid requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    arb_sum   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      arb_sum = {1'b0, ptr_q} + (PtrW+1)'(k);
      if (arb_sum >= (PtrW+1)'(NREQ)) begin
        arb_sum = arb_sum - (PtrW+1)'(NREQ);
      end
      if (!grant_any && i_req_valid[arb_sum[PtrW-1:0]]) begin
        grant[arb_sum[PtrW-1:0]] = 1'b1;
        grant_idx                = arb_sum[PtrW-1:0];
        grant_any                = 1'b1;
      end
    end
  end

  assign o_req_ready = rst ? '0 : grant;
  assign transfer    = grant_any & ~rst;
  assign sel_addr    = req_addr_a[grant_idx];
  assign sel_data    = req_data_a[grant_idx];
  // x0 writes complete the handshake but never reach the write port.
  assign load_wb     = transfer && (sel_addr != 5'd0);

  always_comb begin
    ptr_d = ptr_q;
    if (transfer) begin
      ptr_d = (grant_idx == PtrW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      wvalid_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      wvalid_q <= load_wb;
      if (load_wb) begin
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
      end
    end
  end

  // Clear on commit, then set on issue so a same-edge issue to that register wins.
  always_comb begin
    busy_d = busy_q;
    if (wvalid_q) begin
      busy_d[waddr_q] = 1'b0;
    end
    if (i_issue_valid && (i_issue_rd != 5'd0)) begin
      busy_d[i_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign o_busy_map  = busy_q;
  assign o_rs1_busy  = busy_q[i_rs1_addr];
  assign o_rs2_busy  = busy_q[i_rs2_addr];
  assign o_rd_wvalid = wvalid_q;
  assign o_rd_waddr  = waddr_q;
  assign o_rd_wdata  = wdata_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: expected writebacks are queued when a handshake is seen
// and matched against the write port by a negedge monitor; other checks are inline.
module tb_regfile_wb_scheduler;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREQ = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      i_req_valid = '0;
  logic [NREQ-1:0]      o_req_ready;
  logic [NREQ*5-1:0]    i_req_addr = '0;
  logic [NREQ*XLEN-1:0] i_req_data = '0;
  logic                 i_issue_valid = 1'b0;
  logic [4:0]           i_issue_rd = '0;
  logic [4:0]           i_rs1_addr = '0;
  logic [4:0]           i_rs2_addr = '0;
  logic                 o_rs1_busy;
  logic                 o_rs2_busy;
  logic [31:0]          o_busy_map;
  logic                 o_rd_wvalid;
  logic [4:0]           o_rd_waddr;
  logic [XLEN-1:0]      o_rd_wdata;

  int vectors = 0;
  int miscompares = 0;
  logic [4+XLEN:0] exp_q[$];
  logic [4+XLEN:0] mon_exp;

  regfile_wb_scheduler #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_addr    (i_req_addr),
    .i_req_data    (i_req_data),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .i_rs1_addr    (i_rs1_addr),
    .i_rs2_addr    (i_rs2_addr),
    .o_rs1_busy    (o_rs1_busy),
    .o_rs2_busy    (o_rs2_busy),
    .o_busy_map    (o_busy_map),
    .o_rd_wvalid   (o_rd_wvalid),
    .o_rd_waddr    (o_rd_waddr),
    .o_rd_wdata    (o_rd_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (!rst && o_rd_wvalid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL wb_unexpected: got addr %0d data %h, expected no write",
                 o_rd_waddr, o_rd_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({o_rd_waddr, o_rd_wdata} !== mon_exp) begin
          miscompares++;
          $display("FAIL wb_data: got addr %0d data %h, expected addr %0d data %h",
                   o_rd_waddr, o_rd_wdata, mon_exp[4+XLEN:XLEN], mon_exp[XLEN-1:0]);
        end
      end
    end
  end

  task automatic set_req(input int idx, input logic [4:0] addr, input logic [XLEN-1:0] data);
    i_req_addr[idx*5 +: 5]       = addr;
    i_req_data[idx*XLEN +: XLEN] = data;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    i_req_valid = '0;
    i_issue_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (o_rd_wvalid !== 1'b0) begin
      miscompares++; $display("FAIL reset_wvalid: got %b, expected 0", o_rd_wvalid);
    end
    vectors++;
    if (o_busy_map !== 32'h0) begin
      miscompares++; $display("FAIL reset_busy: got %h, expected 0", o_busy_map);
    end
    vectors++;
    if (o_req_ready !== 3'b000) begin
      miscompares++; $display("FAIL reset_ready_idle: got %b, expected 000", o_req_ready);
    end
    i_req_valid = 3'b001;
    set_req(0, 5'd5, 32'hDEADBEEF);
    #1;
    vectors++;
    if (o_req_ready !== 3'b000) begin
      miscompares++; $display("FAIL reset_ready_valid: got %b, expected 000", o_req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (o_req_ready !== 3'b001) begin
      miscompares++; $display("FAIL first_grant: got %b, expected 001", o_req_ready);
    end
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    @(negedge clk);
    i_req_valid = '0;
    #1;
    vectors++;
    if ({o_rd_wvalid, o_rd_waddr, o_rd_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL first_wb: got v=%b a=%0d d=%h, expected v=1 a=5 d=deadbeef",
               o_rd_wvalid, o_rd_waddr, o_rd_wdata);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0]      rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    int              rr_idx [6] = '{0, 1, 2, 0, 1, 2};
    logic [XLEN-1:0] dat [3] = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003};
    logic [4:0]      adr [3] = '{5'd10, 5'd11, 5'd12};
    apply_reset();
    for (int i = 0; i < 3; i++) set_req(i, adr[i], dat[i]);
    i_req_valid = 3'b111;
    for (int s = 0; s < 6; s++) begin
      #1;
      vectors++;
      if (o_req_ready !== rr_exp[s]) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got %b, expected %b", s, o_req_ready, rr_exp[s]);
      end
      exp_q.push_back({adr[rr_idx[s]], dat[rr_idx[s]]});
      @(negedge clk);
      // Granted requester moves on to a fresh payload.
      dat[rr_idx[s]] = dat[rr_idx[s]] + 32'h0101_0000;
      adr[rr_idx[s]] = adr[rr_idx[s]] + 5'd3;
      set_req(rr_idx[s], adr[rr_idx[s]], dat[rr_idx[s]]);
    end
    i_req_valid = '0;
  endtask

  task automatic test_pointer_wrap();
    @(negedge clk);
    i_req_valid = 3'b001;
    set_req(0, 5'd1, 32'h1111_0001);
    #1;
    vectors++;
    if (o_req_ready !== 3'b001) begin
      miscompares++; $display("FAIL wrap_setup: got %b, expected 001", o_req_ready);
    end
    exp_q.push_back({5'd1, 32'h1111_0001});
    @(negedge clk);
    i_req_valid = 3'b101;
    set_req(0, 5'd2, 32'h2222_0002);
    set_req(2, 5'd13, 32'h3333_0003);
    #1;
    vectors++;
    if (o_req_ready !== 3'b100) begin
      miscompares++; $display("FAIL wrap_grant2: got %b, expected 100", o_req_ready);
    end
    exp_q.push_back({5'd13, 32'h3333_0003});
    @(negedge clk);
    set_req(2, 5'd14, 32'h4444_0004);
    #1;
    vectors++;
    if (o_req_ready !== 3'b001) begin
      miscompares++; $display("FAIL wrap_grant0: got %b, expected 001", o_req_ready);
    end
    exp_q.push_back({5'd2, 32'h2222_0002});
    @(negedge clk);
    i_req_valid = '0;
  endtask

  task automatic test_busy_clear();
    @(negedge clk);
    i_issue_valid = 1'b1;
    i_issue_rd = 5'd7;
    @(negedge clk);
    i_issue_valid = 1'b0;
    i_rs1_addr = 5'd7;
    i_rs2_addr = 5'd8;
    #1;
    vectors++;
    if ({o_busy_map, o_rs1_busy, o_rs2_busy} !== {32'h0000_0080, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL busy_set: got map=%h rs1=%b rs2=%b, expected map=00000080 rs1=1 rs2=0",
               o_busy_map, o_rs1_busy, o_rs2_busy);
    end
    i_req_valid = 3'b001;
    set_req(0, 5'd7, 32'h7777_7777);
    #1;
    vectors++;
    if (o_req_ready !== 3'b001) begin
      miscompares++; $display("FAIL busy_wb_grant: got %b, expected 001", o_req_ready);
    end
    exp_q.push_back({5'd7, 32'h7777_7777});
    @(negedge clk);
    i_req_valid = '0;
    i_rs1_addr = 5'd8;
    i_rs2_addr = 5'd7;
    #1;
    vectors++;
    if ({o_rd_wvalid, o_busy_map[7], o_rs1_busy, o_rs2_busy} !== 4'b1101) begin
      miscompares++;
      $display("FAIL busy_inflight: got wv=%b b7=%b rs1=%b rs2=%b, expected 1 1 0 1",
               o_rd_wvalid, o_busy_map[7], o_rs1_busy, o_rs2_busy);
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({o_busy_map, o_rs2_busy} !== {32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL busy_cleared: got map=%h rs2=%b, expected 0 0", o_busy_map, o_rs2_busy);
    end
  endtask

  task automatic test_set_clear_x0();
    @(negedge clk);
    i_issue_valid = 1'b1;
    i_issue_rd = 5'd9;
    @(negedge clk);
    i_issue_valid = 1'b0;
    i_req_valid = 3'b001;
    set_req(0, 5'd9, 32'h9999_0009);
    #1;
    vectors++;
    if (o_req_ready !== 3'b001) begin
      miscompares++; $display("FAIL same_edge_grant: got %b, expected 001", o_req_ready);
    end
    exp_q.push_back({5'd9, 32'h9999_0009});
    @(negedge clk);
    i_req_valid = '0;
    i_issue_valid = 1'b1;
    i_issue_rd = 5'd9;
    @(negedge clk);
    i_issue_valid = 1'b0;
    #1;
    vectors++;
    if (o_busy_map !== 32'h0000_0200) begin
      miscompares++; $display("FAIL set_wins: got %h, expected 00000200", o_busy_map);
    end
    i_issue_valid = 1'b1;
    i_issue_rd = 5'd0;
    @(negedge clk);
    i_issue_valid = 1'b0;
    #1;
    vectors++;
    if (o_busy_map !== 32'h0000_0200) begin
      miscompares++; $display("FAIL issue_x0: got %h, expected 00000200", o_busy_map);
    end
    i_req_valid = 3'b010;
    set_req(1, 5'd0, 32'h0000_1234);
    #1;
    vectors++;
    if (o_req_ready !== 3'b010) begin
      miscompares++; $display("FAIL x0_grant: got %b, expected 010", o_req_ready);
    end
    @(negedge clk);
    i_req_valid = 3'b011;
    set_req(1, 5'd15, 32'h5555_0015);
    set_req(0, 5'd14, 32'h6666_0014);
    #1;
    vectors++;
    if (o_rd_wvalid !== 1'b0) begin
      miscompares++; $display("FAIL x0_no_write: got %b, expected 0", o_rd_wvalid);
    end
    // Pointer must have moved past requester 1 despite the x0 target.
    vectors++;
    if (o_req_ready !== 3'b001) begin
      miscompares++; $display("FAIL x0_ptr_adv: got %b, expected 001", o_req_ready);
    end
    exp_q.push_back({5'd14, 32'h6666_0014});
    @(negedge clk);
    i_req_valid = '0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_req_valid = 3'b001;
    set_req(0, 5'd3, 32'hBAD0_0003);
    #1;
    vectors++;
    if (o_req_ready !== 3'b001) begin
      miscompares++; $display("FAIL mid_grant: got %b, expected 001", o_req_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({o_rd_wvalid, o_rd_waddr} !== {1'b1, 5'd3}) begin
      miscompares++;
      $display("FAIL mid_loaded: got v=%b a=%0d, expected v=1 a=3", o_rd_wvalid, o_rd_waddr);
    end
    #1;
    rst = 1'b1;
    i_req_valid = '0;
    #1;
    vectors++;
    if ({o_rd_wvalid, o_busy_map} !== {1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL mid_reset: got v=%b map=%h, expected v=0 map=0", o_rd_wvalid, o_busy_map);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (o_rd_wvalid !== 1'b0) begin
      miscompares++; $display("FAIL mid_no_write: got %b, expected 0", o_rd_wvalid);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_pointer_wrap();
    test_busy_clear();
    test_set_clear_x0();
    test_reset_mid();
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL wb_missing: got %0d outstanding writes, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
